// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-port arbiters.
// The package holds the port count, the FSM state type, the reset priority and the one-hot helpers.
package noc_arb_pkg;

    localparam int unsigned N_PORTS = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic [N_PORTS-1:0] RST_PRIORITY = 4'b0001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } rr_state_e;

    function automatic logic is_onehot4(input logic [N_PORTS-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_PORTS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (v[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational circular priority search over four requesters.
// The search starts at the one-hot priority position and moves upward, wrapping from 3 to 0.
module rr_pick_4
    import noc_arb_pkg::*;
(
    input  logic [N_PORTS-1:0] req_i,
    input  logic [N_PORTS-1:0] priority_order_i,
    output logic [N_PORTS-1:0] grant_oh_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               valid_o
);

    logic [N_PORTS-1:0] w_prio;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_cand;

    always_comb begin
        w_prio      = is_onehot4(priority_order_i) ? priority_order_i : RST_PRIORITY;
        w_start     = onehot_to_idx(w_prio);
        w_cand      = '0;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        // The 2-bit add wraps modulo 4, which gives the circular search order.
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_cand = w_start + IDX_W'(i);
            if (!valid_o && req_i[w_cand]) begin
                valid_o             = 1'b1;
                grant_oh_o[w_cand]  = 1'b1;
                grant_idx_o         = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Four-port round-robin wormhole grant controller.
// A grant is held from the head flit to the tail flit. Tail acceptance pulses change_order_o so the priority register rotates.
module rr_grant_ctrl
    import noc_arb_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_PORTS-1:0]  req_i,
    input  logic [N_PORTS-1:0]  flit_valid_i,
    input  logic [N_PORTS-1:0]  flit_tail_i,
    input  logic [N_PORTS-1:0]  priority_order_i,
    input  logic                out_ready_i,
    output logic [N_PORTS-1:0]  grant_o,
    output logic [IDX_W-1:0]    grant_idx_o,
    output logic [N_PORTS-1:0]  in_ready_o,
    output logic                out_valid_o,
    output logic                change_order_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    pkt_flits_o
);

    rr_state_e          r_state;
    logic [N_PORTS-1:0] r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_change_order;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_pkt_flits;

    logic [N_PORTS-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic               w_xfer;
    logic               w_tail;
    logic [CNT_W-1:0]   w_cnt_next;

    rr_pick_4 u_pick (
        .req_i            (req_i),
        .priority_order_i (priority_order_i),
        .grant_oh_o       (w_pick_oh),
        .grant_idx_o      (w_pick_idx),
        .valid_o          (w_pick_valid)
    );

    assign w_xfer     = (|(r_grant & flit_valid_i)) & out_ready_i;
    assign w_tail     = |(r_grant & flit_valid_i & flit_tail_i);
    assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_grant        <= '0;
            r_grant_idx    <= '0;
            r_change_order <= 1'b0;
            r_cnt          <= '0;
            r_pkt_flits    <= '0;
        end else begin
            r_change_order <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant     <= w_pick_oh;
                        r_grant_idx <= w_pick_idx;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_xfer) begin
                        r_cnt <= w_cnt_next;
                        if (w_tail) begin
                            r_grant        <= '0;
                            r_grant_idx    <= '0;
                            r_change_order <= 1'b1;
                            r_state        <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    // The counter already includes the tail flit here.
                    r_pkt_flits <= r_cnt;
                    r_cnt       <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_o        = r_grant;
    assign grant_idx_o    = r_grant_idx;
    assign in_ready_o     = r_grant & {N_PORTS{out_ready_i}};
    assign out_valid_o    = |(r_grant & flit_valid_i);
    assign change_order_o = r_change_order;
    assign busy_o         = (r_state != IDLE);
    assign pkt_flits_o    = r_pkt_flits;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed self-checking bench for rr_grant_ctrl.
// It includes a behavioural model of the rotating priority register.
module tb_rr_grant_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_i;
    logic [3:0] flit_valid_i;
    logic [3:0] flit_tail_i;
    logic [3:0] priority_order_i;
    logic       out_ready_i;
    logic [3:0] grant_o;
    logic [1:0] grant_idx_o;
    logic [3:0] in_ready_o;
    logic       out_valid_o;
    logic       change_order_o;
    logic       busy_o;
    logic [7:0] pkt_flits_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [3:0] prio_reg;
    logic       use_ovr;
    logic [3:0] prio_ovr;

    always #5 clk = ~clk;

    // Priority register model: it rotates toward lower indices on each change_order pulse.
    always @(posedge clk) begin
        if (reset) prio_reg <= 4'b0001;
        else if (change_order_o) prio_reg <= {prio_reg[0], prio_reg[3:1]};
    end

    assign priority_order_i = use_ovr ? prio_ovr : prio_reg;

    rr_grant_ctrl #(.CNT_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_i            (req_i),
        .flit_valid_i     (flit_valid_i),
        .flit_tail_i      (flit_tail_i),
        .priority_order_i (priority_order_i),
        .out_ready_i      (out_ready_i),
        .grant_o          (grant_o),
        .grant_idx_o      (grant_idx_o),
        .in_ready_o       (in_ready_o),
        .out_valid_o      (out_valid_o),
        .change_order_o   (change_order_o),
        .busy_o           (busy_o),
        .pkt_flits_o      (pkt_flits_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rq, input logic [3:0] v, input logic [3:0] t, input logic rdy);
        req_i        = rq;
        flit_valid_i = v;
        flit_tail_i  = t;
        out_ready_i  = rdy;
        #1;
    endtask

    logic [3:0] rr_seq [4];

    initial begin
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b1000;
        rr_seq[2] = 4'b0100; rr_seq[3] = 4'b0010;
        use_ovr = 1'b0;
        prio_ovr = 4'b0000;
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
        cyc();
        cyc();
        chk("rst_grant", grant_o, 4'b0000);
        chk("rst_idx", grant_idx_o, 2'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_chg", change_order_o, 1'b0);
        chk("rst_pkt", pkt_flits_o, 8'd0);
        reset = 1'b0;

        // Test 1: request 0110 with priority 0001 selects port 1, then a 3-flit packet follows.
        drive(4'b0110, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t1_grant", grant_o, 4'b0010);
        chk("t1_idx", grant_idx_o, 2'd1);
        chk("t1_busy", busy_o, 1'b1);
        drive(4'b0000, 4'b0010, 4'b0000, 1'b1);
        chk("t1_inrdy", in_ready_o, 4'b0010);
        chk("t1_ovalid", out_valid_o, 1'b1);
        cyc();
        cyc();
        drive(4'b0000, 4'b0010, 4'b0010, 1'b1);
        cyc();
        chk("t1_rel_grant", grant_o, 4'b0000);
        chk("t1_rel_chg", change_order_o, 1'b1);
        chk("t1_rel_busy", busy_o, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t1_idle_chg", change_order_o, 1'b0);
        chk("t1_idle_busy", busy_o, 1'b0);
        chk("t1_pkt", pkt_flits_o, 8'd3);

        // Test 2: priority 1000 with requests 0101 wraps around to port 0.
        use_ovr  = 1'b1;
        prio_ovr = 4'b1000;
        drive(4'b0101, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t2_grant", grant_o, 4'b0001);
        chk("t2_idx", grant_idx_o, 2'd0);
        drive(4'b0000, 4'b0001, 4'b0001, 1'b1);
        cyc();
        chk("t2_chg", change_order_o, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t2_pkt", pkt_flits_o, 8'd1);
        use_ovr = 1'b0;

        // Test 3: all ports request continuously with single-flit packets, giving the rotation order.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t3_rst_pkt", pkt_flits_o, 8'd0);
        drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("t3_grant%0d", k), grant_o, rr_seq[k % 4]);
            cyc();
            chk($sformatf("t3_chg%0d", k), change_order_o, 1'b1);
            cyc();
            chk($sformatf("t3_pkt%0d", k), pkt_flits_o, 8'd1);
        end
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Test 4: a 5-cycle downstream stall in the middle of a 2-flit packet.
        drive(4'b0100, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t4_grant", grant_o, 4'b0100);
        drive(4'b0000, 4'b0100, 4'b0000, 1'b1);
        cyc();
        drive(4'b0000, 4'b0100, 4'b0100, 1'b0);
        chk("t4_inrdy_stall", in_ready_o, 4'b0000);
        chk("t4_ovalid_stall", out_valid_o, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("t4_hold%0d", k), grant_o, 4'b0100);
            chk($sformatf("t4_pkt%0d", k), pkt_flits_o, 8'd1);
        end
        drive(4'b0000, 4'b0100, 4'b0100, 1'b1);
        cyc();
        chk("t4_rel_chg", change_order_o, 1'b1);
        chk("t4_rel_pkt", pkt_flits_o, 8'd1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t4_pkt", pkt_flits_o, 8'd2);

        // Test 5: a non-granted port shows a valid tail flit, which must have no effect.
        drive(4'b0001, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t5_grant", grant_o, 4'b0001);
        drive(4'b0010, 4'b0010, 4'b0010, 1'b1);
        chk("t5_inrdy", in_ready_o, 4'b0001);
        chk("t5_ovalid", out_valid_o, 1'b0);
        cyc();
        cyc();
        chk("t5_hold", grant_o, 4'b0001);
        chk("t5_nochg", change_order_o, 1'b0);
        chk("t5_busy", busy_o, 1'b1);
        drive(4'b0000, 4'b0001, 4'b0001, 1'b1);
        cyc();
        chk("t5_chg", change_order_o, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t5_pkt", pkt_flits_o, 8'd1);

        // Test 6: reset asserted during GRANT after 2 flits.
        drive(4'b1000, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t6_grant", grant_o, 4'b1000);
        drive(4'b0000, 4'b1000, 4'b0000, 1'b1);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk("t6_grant_rst", grant_o, 4'b0000);
        chk("t6_idx_rst", grant_idx_o, 2'd0);
        chk("t6_busy_rst", busy_o, 1'b0);
        chk("t6_chg_rst", change_order_o, 1'b0);
        chk("t6_pkt_rst", pkt_flits_o, 8'd0);
        reset = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t6_chg_after", change_order_o, 1'b0);

        // Test 7: a 301-flit packet saturates the counter at 255.
        drive(4'b0010, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t7_grant", grant_o, 4'b0010);
        drive(4'b0000, 4'b0010, 4'b0000, 1'b1);
        for (int k = 0; k < 300; k++) cyc();
        drive(4'b0000, 4'b0010, 4'b0010, 1'b1);
        cyc();
        chk("t7_chg", change_order_o, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc();
        chk("t7_pkt_sat", pkt_flits_o, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
